// File: rtl/apb_master.sv
// APB requester: turns a valid/ready command into one APB SETUP/ACCESS transfer and returns a
// single-cycle response pulse, aborting with a timeout when the slave never asserts pready.
module apb_master #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              pclk,
    input  logic              preset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] CntLast = (TIMEOUT > 0) ? CntW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e          state_q;
    logic [CntW-1:0] wait_cnt_q;
    logic            timeout_hit;

    always_comb begin
        timeout_hit = (TIMEOUT != 0) && (wait_cnt_q == CntLast);
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q     <= StIdle;
            wait_cnt_q  <= '0;
            cmd_ready   <= 1'b0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            case (state_q)
                StIdle: begin
                    cmd_ready <= 1'b1;
                    psel      <= 1'b0;
                    penable   <= 1'b0;
                    // cmd_ready is itself registered, so the first edge after reset never accepts
                    if (cmd_valid && cmd_ready) begin
                        pwrite    <= cmd_write;
                        paddr     <= cmd_addr;
                        pwdata    <= cmd_wdata;
                        psel      <= 1'b1;
                        cmd_ready <= 1'b0;
                        state_q   <= StSetup;
                    end
                end
                StSetup: begin
                    penable    <= 1'b1;
                    wait_cnt_q <= '0;
                    state_q    <= StAccess;
                end
                StAccess: begin
                    if (pready) begin
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        cmd_ready <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_err   <= pslverr;
                        rsp_rdata <= pwrite ? '0 : prdata;
                        state_q   <= StIdle;
                    end else if (timeout_hit) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        cmd_ready   <= 1'b1;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                        state_q     <= StIdle;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                default: begin
                    psel      <= 1'b0;
                    penable   <= 1'b0;
                    cmd_ready <= 1'b0;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

endmodule
